// File: rtl/seq_match_reporter_pkg.sv
// Shared types and default sizing for the match reporter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package seq_det_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } rpt_state_t;

    localparam int DEF_CNT_W      = 4;
    localparam int DEF_WIN_CYCLES = 16;

endpackage

// File: rtl/seq_match_reporter_if.sv
// Control, match input and report handshake bundle for the match reporter.
// Latency: n/a (wiring only).
// Backpressure: rpt_ready from the consumer holds the report fields stable.
interface seq_match_reporter_if #(
    parameter int CNT_W = 4
);
    logic             en;
    logic             y_in;
    logic             rpt_ready;
    logic             rpt_valid;
    logic [CNT_W-1:0] rpt_count;
    logic             rpt_sat;
    logic             rpt_drop;
    logic             busy;

    // Driver side: controls the reporter and consumes reports.
    modport master (
        output en, y_in, rpt_ready,
        input  rpt_valid, rpt_count, rpt_sat, rpt_drop, busy
    );

    // Reporter side.
    modport slave (
        input  en, y_in, rpt_ready,
        output rpt_valid, rpt_count, rpt_sat, rpt_drop, busy
    );
endinterface

// File: rtl/seq_match_sat_counter.sv
// Saturating event counter with sticky overflow flag; clr wins over inc.
// Latency: cnt/sat update 1 clk after clr/inc.
// Backpressure: none.
module seq_match_sat_counter #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt,
    output logic             sat
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Count up to the ceiling; an increment arriving at the ceiling sets sat.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
            sat <= 1'b0;
        end else if (inc) begin
            if (cnt == CNT_MAX) begin
                sat <= 1'b1;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end
endmodule

// File: rtl/seq_match_reporter.sv
// Counts rising edges of the match flag per fixed window and reports each window.
// Latency: report valid 1 clk after the window's last cycle.
// Backpressure: a window closing while a report is held unaccepted is dropped and flagged.
module seq_match_reporter
    import seq_det_pkg::*;
#(
    parameter int CNT_W      = DEF_CNT_W,
    parameter int WIN_CYCLES = DEF_WIN_CYCLES
) (
    input  logic                 clk,
    input  logic                 rst,
    seq_match_reporter_if.slave  bus
);
    localparam int               TMR_W    = $clog2(WIN_CYCLES);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(WIN_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    rpt_state_t       state_q, state_d;
    logic [TMR_W-1:0] timer_q;
    logic             y_q;
    logic             y_edge;
    logic             clr, inc, close, load;
    logic [CNT_W-1:0] cnt, final_cnt;
    logic             sat, final_sat;
    logic             drop_pending_q;
    logic             rpt_valid_q, rpt_sat_q, rpt_drop_q;
    logic [CNT_W-1:0] rpt_count_q;

    assign y_edge = bus.y_in & ~y_q;

    // Close-cycle result folds in an edge landing on the last window cycle.
    assign final_cnt = (y_edge && cnt != CNT_MAX) ? cnt + CNT_W'(1) : cnt;
    assign final_sat = sat | (y_edge & (cnt == CNT_MAX));

    // A report slot is free if empty or being handed off this cycle.
    assign load = close & (~rpt_valid_q | bus.rpt_ready);

    seq_match_sat_counter #(.CNT_W(CNT_W)) u_cnt (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .inc (inc),
        .cnt (cnt),
        .sat (sat)
    );

    // Delayed copy of the match flag for rising-edge detection.
    always_ff @(posedge clk) begin
        if (rst) y_q <= 1'b0;
        else     y_q <= bus.y_in;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next state and counter control; counter is held clear outside live windows.
    always_comb begin
        state_d = state_q;
        clr     = 1'b1;
        inc     = 1'b0;
        close   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.en) state_d = RUN;
            end
            RUN: begin
                if (!bus.en) begin
                    state_d = IDLE;
                end else if (timer_q == TMR_LAST) begin
                    close = 1'b1;
                end else begin
                    clr = 1'b0;
                    inc = y_edge;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Window timer: tracks the RUN cycle index, restarts at close or abort.
    always_ff @(posedge clk) begin
        if (rst || state_q != RUN || !bus.en || close) timer_q <= '0;
        else                                          timer_q <= timer_q + TMR_W'(1);
    end

    // Report slot and drop bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            rpt_valid_q    <= 1'b0;
            rpt_count_q    <= '0;
            rpt_sat_q      <= 1'b0;
            rpt_drop_q     <= 1'b0;
            drop_pending_q <= 1'b0;
        end else if (load) begin
            rpt_valid_q    <= 1'b1;
            rpt_count_q    <= final_cnt;
            rpt_sat_q      <= final_sat;
            rpt_drop_q     <= drop_pending_q;
            drop_pending_q <= 1'b0;
        end else begin
            if (close) drop_pending_q <= 1'b1;
            if (rpt_valid_q && bus.rpt_ready) rpt_valid_q <= 1'b0;
        end
    end

    assign bus.rpt_valid = rpt_valid_q;
    assign bus.rpt_count = rpt_count_q;
    assign bus.rpt_sat   = rpt_sat_q;
    assign bus.rpt_drop  = rpt_drop_q;
    assign bus.busy      = (state_q == RUN);
endmodule

// File: tb/tb_seq_match_reporter.sv
// Directed bench for the match reporter: 16-cycle and 64-cycle window instances.
// Latency: n/a.
// Backpressure: rpt_ready driven per step.
module tb_seq_match_reporter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests  = 0;
    int   failed = 0;

    seq_match_reporter_if #(.CNT_W(4)) bus ();
    seq_match_reporter_if #(.CNT_W(4)) bus64 ();

    seq_match_reporter #(.CNT_W(4), .WIN_CYCLES(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    seq_match_reporter #(.CNT_W(4), .WIN_CYCLES(64)) dut64 (
        .clk (clk),
        .rst (rst),
        .bus (bus64.slave)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive y_in from mask bit i on step i, one clock per step.
    task automatic run_cycles(input bit sel64, input logic [63:0] mask, input int n);
        for (int i = 0; i < n; i++) begin
            if (sel64) bus64.y_in = mask[i];
            else       bus.y_in   = mask[i];
            tick();
        end
        if (sel64) bus64.y_in = 1'b0;
        else       bus.y_in   = 1'b0;
    endtask

    task automatic chk_rpt(input bit sel64, input string tag, input logic v,
                           input logic [3:0] c, input logic s, input logic d);
        if (sel64) begin
            chk({tag, ".valid"}, {7'd0, bus64.rpt_valid}, {7'd0, v});
            chk({tag, ".count"}, {4'd0, bus64.rpt_count}, {4'd0, c});
            chk({tag, ".sat"},   {7'd0, bus64.rpt_sat},   {7'd0, s});
            chk({tag, ".drop"},  {7'd0, bus64.rpt_drop},  {7'd0, d});
        end else begin
            chk({tag, ".valid"}, {7'd0, bus.rpt_valid}, {7'd0, v});
            chk({tag, ".count"}, {4'd0, bus.rpt_count}, {4'd0, c});
            chk({tag, ".sat"},   {7'd0, bus.rpt_sat},   {7'd0, s});
            chk({tag, ".drop"},  {7'd0, bus.rpt_drop},  {7'd0, d});
        end
    endtask

    initial begin
        bus.en = 1'b0;   bus.y_in = 1'b0;   bus.rpt_ready = 1'b1;
        bus64.en = 1'b0; bus64.y_in = 1'b0; bus64.rpt_ready = 1'b1;

        // Reset state
        tick();
        tick();
        chk_rpt(0, "reset", 1'b0, 4'd0, 1'b0, 1'b0);
        chk("reset.busy", {7'd0, bus.busy}, 8'd0);
        rst = 1'b0;

        // 1: three single-cycle pulses, report one clock after cycle 15
        bus.en = 1'b1;
        tick();
        chk("t1.busy", {7'd0, bus.busy}, 8'd1);
        run_cycles(0, 64'h0111, 16);
        chk_rpt(0, "t1", 1'b1, 4'd3, 1'b0, 1'b0);

        // 2: level held 5 cycles counts once; previous report handed off
        tick();
        chk("t2.valid_fall", {7'd0, bus.rpt_valid}, 8'd0);
        run_cycles(0, 64'h3E, 15);
        chk_rpt(0, "t2", 1'b1, 4'd1, 1'b0, 1'b0);

        // 4: stall across two closes
        tick();
        chk("t4.handoff", {7'd0, bus.rpt_valid}, 8'd0);
        bus.rpt_ready = 1'b0;
        run_cycles(0, 64'h0A, 15);
        chk_rpt(0, "t4.first", 1'b1, 4'd2, 1'b0, 1'b0);
        run_cycles(0, 64'h55, 16);
        chk_rpt(0, "t4.held", 1'b1, 4'd2, 1'b0, 1'b0);
        bus.rpt_ready = 1'b1;
        tick();
        chk("t4.accept", {7'd0, bus.rpt_valid}, 8'd0);
        run_cycles(0, 64'h10, 15);
        chk_rpt(0, "t4.after_drop", 1'b1, 4'd1, 1'b0, 1'b1);

        // 5: abort at RUN cycle 8, edge in the IDLE cycle ignored, fresh window
        run_cycles(0, 64'h0A, 8);
        bus.en = 1'b0;
        tick();
        chk("t5.abort_busy", {7'd0, bus.busy}, 8'd0);
        chk("t5.no_report", {7'd0, bus.rpt_valid}, 8'd0);
        bus.en   = 1'b1;
        bus.y_in = 1'b1;
        tick();
        chk("t5.rerun_busy", {7'd0, bus.busy}, 8'd1);
        bus.rpt_ready = 1'b0;
        run_cycles(0, 64'h224, 16);
        chk_rpt(0, "t5.fresh", 1'b1, 4'd3, 1'b0, 1'b0);
        run_cycles(0, 64'h155, 15);
        chk("t5.stable", {4'd0, bus.rpt_count}, 8'd3);
        bus.rpt_ready = 1'b1;
        tick();
        chk_rpt(0, "t5.b2b", 1'b1, 4'd5, 1'b0, 1'b0);

        // 6: reset mid-window with a report held
        bus.rpt_ready = 1'b0;
        run_cycles(0, 64'h2, 3);
        chk("t6.pre_valid", {7'd0, bus.rpt_valid}, 8'd1);
        chk("t6.pre_busy", {7'd0, bus.busy}, 8'd1);
        rst = 1'b1;
        tick();
        chk_rpt(0, "t6.rst", 1'b0, 4'd0, 1'b0, 1'b0);
        chk("t6.rst_busy", {7'd0, bus.busy}, 8'd0);
        rst    = 1'b0;
        bus.en = 1'b0;

        // 3: 64-cycle window, 20 pulses saturate, then an empty window clears sat
        bus64.en = 1'b1;
        tick();
        chk("t3.busy", {7'd0, bus64.busy}, 8'd1);
        run_cycles(1, 64'h55_5555_5555, 64);
        chk_rpt(1, "t3.sat", 1'b1, 4'd15, 1'b1, 1'b0);
        run_cycles(1, 64'h0, 64);
        chk_rpt(1, "t3.empty", 1'b1, 4'd0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
